mux17_rr_arbiter: RTL

- Shares the 17-bit two-input mux datapath between two requesters (lane 0, lane 1). Each requester presents a 17-bit word with a valid/ready handshake.
- The block generates the mux select using round-robin arbitration with a bounded burst length.
- The selected word is registered into a single output stage with its own valid/ready handshake.
- It sits in front of the shared 17-bit path in the SIMD execute stage and is the only driver of that path's select.

---
 rtl/mux17_rr_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/mux17_rr_arbiter.sv
// Two-lane round-robin arbiter with bounded bursts driving the shared 17-bit mux select,
// followed by a single registered output stage with valid/ready handshake.
module mux17_rr_arbiter #(
  parameter int WIDTH     = 17,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_src_q,   out_src_d;
  logic             prio_q,      prio_d;
  logic             last_q,      last_d;
  logic [3:0]       cnt_q,       cnt_d;
  logic             sel_q,       sel_d;

  logic slot_free, any_req, gnt, grant_en;

  always_comb begin
    slot_free = !out_valid_q | out_ready;
    any_req   = req0_valid | req1_valid;
    // Contention: pointer decides a fresh burst, otherwise continue last lane until the cap.
    if (req0_valid && req1_valid) begin
      if (cnt_q == 4'd0)       gnt = prio_q;
      else if (cnt_q < MAX_B)  gnt = last_q;
      else                     gnt = ~last_q;
    end else begin
      gnt = req1_valid;
    end
    grant_en   = reset_n & slot_free & any_req;
    sel        = grant_en ? gnt : sel_q;
    req0_ready = grant_en & ~gnt;
    req1_ready = grant_en & gnt;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    prio_d      = prio_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    if (grant_en) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt ? req1_data : req0_data;
      out_src_d   = gnt;
      prio_d      = ~gnt;
      sel_d       = gnt;
      if (gnt == last_q) begin
        cnt_d = (cnt_q >= MAX_B) ? MAX_B : cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd1;
        last_d = gnt;
      end
    end else if (out_ready && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      prio_q      <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= 4'd0;
      sel_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      prio_q      <= prio_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
